inv_key_expansion: RTL

Reverse AES-128 key schedule. Accepts the final round key (round Nr) and regenerates all round keys back to the cipher key (round 0), one round per three cycles. Fills the same packed round-key bus layout that the forward key expansion produces. Sits in front of the decryption datapath so the inverse cipher can be fed from the last round key alone.

---
 rtl/inv_key_expansion.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: rebuilds round keys Nr..0 from the
// final round key, one round every three cycles.

module inv_key_expansion #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [127:0]          lastKey,
  output logic [(Nr+1)*128-1:0] keysOut,
  output logic                  key_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int KW = Nk * 32;
  localparam logic [3:0] NR4 = 4'(Nr);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XOR,
    S_SUB,
    S_COMMIT
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0] cur_key;
  logic [3:0]    rnd;
  logic [31:0]   w1_r, w2_r, w3_r;
  logic [31:0]   sub_r;
  logic [7:0]    rcon_r;
  logic [31:0]   v0, v1, v2, v3;
  logic [31:0]   rot_w, sub_w;
  logic [127:0]  new_key;
  logic          ld_key, ld_xor, ld_sub;
  logic          ld_commit, fin;

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] c;
    unique case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  assign v0 = cur_key[127:96];
  assign v1 = cur_key[95:64];
  assign v2 = cur_key[63:32];
  assign v3 = cur_key[31:0];

  assign rot_w = {w3_r[23:0], w3_r[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    SubTable u_sub (
      .din  (rot_w[i*8 +: 8]),
      .dout (sub_w[i*8 +: 8])
    );
  end

  assign new_key = {
    v0 ^ sub_r ^ {rcon_r, 24'h0},
    w1_r, w2_r, w3_r
  };

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_XOR;
      S_XOR:    state_nx = S_SUB;
      S_SUB:    state_nx = S_COMMIT;
      S_COMMIT: begin
        if (rnd == 4'd1) state_nx = S_IDLE;
        else             state_nx = S_XOR;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ld_key    = (state == S_IDLE) && start;
    ld_xor    = (state == S_XOR);
    ld_sub    = (state == S_SUB);
    ld_commit = (state == S_COMMIT);
    fin       = ld_commit && (rnd == 4'd1);
  end

  // Slots not reached by this run keep whatever they held before.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_key   <= '0;
      rnd       <= '0;
      w1_r      <= '0;
      w2_r      <= '0;
      w3_r      <= '0;
      sub_r     <= '0;
      rcon_r    <= '0;
      keysOut   <= '0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        ld_key: begin
          cur_key       <= lastKey;
          keysOut[127:0] <= lastKey;
          rnd           <= NR4;
          busy          <= 1'b1;
          key_ready     <= 1'b0;
        end
        ld_xor: begin
          w3_r <= v3 ^ v2;
          w2_r <= v2 ^ v1;
          w1_r <= v1 ^ v0;
        end
        ld_sub: begin
          sub_r  <= sub_w;
          rcon_r <= rcon(rnd);
        end
        ld_commit: begin
          cur_key <= new_key;
          rnd     <= rnd - 4'd1;
          for (int k = 0; k < Nr; k++) begin
            if (rnd == 4'(k + 1))
              keysOut[(Nr+1-k)*128-1 -: 128] <= new_key;
          end
          if (fin) begin
            busy      <= 1'b0;
            key_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module SubTable (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  logic [7:0] sq, inv;

  // GF(2^8) inverse as x^254 = x^2 * x^4 * ... * x^128.
  always_comb begin
    inv = 8'h01;
    sq  = din;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign dout = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule
